// File: rtl/pito_mvu_apb_arb.sv
// Round-robin arbiter funnelling per-hart MVU CSR requests onto one APB master port.
// One transaction in flight; illegal addresses and ACCESS timeouts answer with an error.
module pito_mvu_apb_arb #(
  parameter int          NUM_HARTS          = 8,
  parameter logic [11:0] MVU_CSR_START_ADDR = 12'hF20,
  parameter int          TIMEOUT            = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      req_valid_i,
  input  logic [NUM_HARTS-1:0]      req_write_i,
  input  logic [NUM_HARTS*12-1:0]   req_addr_i,
  input  logic [NUM_HARTS*32-1:0]   req_wdata_i,
  output logic [NUM_HARTS-1:0]      req_ready_o,
  output logic [NUM_HARTS-1:0]      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [11:0]               apb_paddr,
  output logic [31:0]               apb_pwdata,
  output logic                      apb_pwrite,
  output logic                      apb_psel,
  output logic                      apb_penable,
  input  logic [31:0]               apb_prdata,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr,
  output logic                      busy_o
);
  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e               state_q;
  logic [HW-1:0]        hart_q, last_q;
  logic [11:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 write_q;
  logic [7:0]           wait_q;
  logic                 psel_q, penable_q;
  logic [NUM_HARTS-1:0] rsp_valid_q;
  logic [31:0]          rsp_rdata_q;
  logic                 rsp_err_q;

  logic [NUM_HARTS-1:0][11:0] addr_v;
  logic [NUM_HARTS-1:0][31:0] wdata_v;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_unpack
    assign addr_v[g]  = req_addr_i[12*g +: 12];
    assign wdata_v[g] = req_wdata_i[32*g +: 32];
  end

  // First valid hart scanning upward from the one after the last served hart.
  logic          gnt_any;
  logic [HW-1:0] gnt_idx;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      if (!gnt_any && req_valid_i[HW'(int'(last_q) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = HW'(int'(last_q) + k);
      end
    end
  end

  logic [NUM_HARTS-1:0] gnt_oh, hart_oh;
  logic                 gnt_legal;
  logic [7:0]           wait_inc;

  assign gnt_oh    = gnt_any ? (NUM_HARTS'(1) << gnt_idx) : '0;
  assign hart_oh   = NUM_HARTS'(1) << hart_q;
  assign gnt_legal = addr_v[gnt_idx] >= MVU_CSR_START_ADDR;
  assign wait_inc  = wait_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hart_q      <= '0;
      last_q      <= HW'(NUM_HARTS - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            hart_q  <= gnt_idx;
            addr_q  <= addr_v[gnt_idx];
            wdata_q <= wdata_v[gnt_idx];
            write_q <= req_write_i[gnt_idx];
            if (gnt_legal) begin
              state_q <= SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= gnt_oh;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        ACCESS: begin
          if (apb_pready) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= hart_oh;
            rsp_rdata_q <= write_q ? 32'd0 : apb_prdata;
            rsp_err_q   <= apb_pslverr;
          end else begin
            wait_q <= wait_inc;
            if (wait_inc == 8'(TIMEOUT)) begin
              state_q     <= RESP;
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              rsp_valid_q <= hart_oh;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          last_q  <= hart_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so every output reads zero while rst_n is low.
  assign req_ready_o = (state_q == IDLE && rst_n) ? gnt_oh : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_paddr   = psel_q ? addr_q : 12'd0;
  assign apb_pwdata  = psel_q ? wdata_q : 32'd0;
  assign apb_pwrite  = psel_q & write_q;
  assign busy_o      = state_q != IDLE;

endmodule
